radar_sweep_ctrl: RTL

Sweep sequencer for the ultrasonic radar. Drives the servo PWM through N_POS angle positions, bouncing 0→N_POS-1→0. At each position it waits for the servo to settle, then requests one range measurement from the trigger/echo/distance chain and consumes the resulting distance_cm. Emits one angle/distance sample per position and a per-sweep nearest-object summary for the display/alarm logic downstream.

---
 rtl/radar_pkg.sv | 16 +
 rtl/radar_sweep_ctrl_if.sv | 28 ++
 rtl/servo_pwm_gen.sv | 36 +++
 rtl/radar_sweep_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/radar_pkg.sv
// Shared types and constants for the radar sweep controller.
package radar_pkg;

    localparam int unsigned DIST_W = 11;
    localparam int unsigned IDX_W  = 4;
    localparam logic [DIST_W-1:0] DIST_NONE = 11'h7FF;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeasure,
        StReport,
        StAdvance
    } state_e;

endpackage

// File: rtl/radar_sweep_ctrl_if.sv
// Measurement handshake and sample/summary bus of the sweep controller.
interface radar_sweep_ctrl_if;
    import radar_pkg::*;

    logic              meas_req;
    logic              meas_valid;
    logic [DIST_W-1:0] distance_cm;
    logic              sample_valid;
    logic [IDX_W-1:0]  sample_idx;
    logic [DIST_W-1:0] sample_cm;
    logic              sample_timeout;
    logic              sweep_done;
    logic [DIST_W-1:0] nearest_cm;
    logic [IDX_W-1:0]  nearest_idx;

    modport master (
        output meas_req, sample_valid, sample_idx, sample_cm, sample_timeout,
               sweep_done, nearest_cm, nearest_idx,
        input  meas_valid, distance_cm
    );

    modport slave (
        input  meas_req, sample_valid, sample_idx, sample_cm, sample_timeout,
               sweep_done, nearest_cm, nearest_idx,
        output meas_valid, distance_cm
    );

endinterface

// File: rtl/servo_pwm_gen.sv
// Free-running servo frame counter; pulse width is re-latched only at frame wrap.
module servo_pwm_gen import radar_pkg::*; #(
    parameter int unsigned SERVO_PERIOD = 20000,
    parameter int unsigned PULSE_MIN    = 1000,
    parameter int unsigned PULSE_STEP   = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] angle_idx,
    output logic             servo_pwm,
    output logic             wrap
);

    localparam int unsigned CNT_W = $clog2(SERVO_PERIOD + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] width_d;

    assign wrap      = (cnt_q == CNT_W'(SERVO_PERIOD - 1));
    assign width_d   = CNT_W'(PULSE_MIN + PULSE_STEP * 32'(angle_idx));
    assign servo_pwm = (cnt_q < width_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            width_q <= '0;
        end else if (wrap) begin
            cnt_q   <= '0;
            width_q <= width_d;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/radar_sweep_ctrl.sv
// Bouncing servo sweep: settle, measure, report one sample per position, summarise per sweep.
module radar_sweep_ctrl import radar_pkg::*; #(
    parameter int unsigned SERVO_PERIOD  = 20000,
    parameter int unsigned PULSE_MIN     = 1000,
    parameter int unsigned PULSE_STEP    = 80,
    parameter int unsigned N_POS         = 13,
    parameter int unsigned SETTLE_FRAMES = 3,
    parameter int unsigned MEAS_TIMEOUT  = 60000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 servo_pwm,
    output logic [IDX_W-1:0]     angle_idx,
    radar_sweep_ctrl_if.master   bus
);

    localparam int unsigned SET_W = $clog2(SETTLE_FRAMES + 1);
    localparam int unsigned TMO_W = $clog2(MEAS_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              dir_up_q, dir_up_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [IDX_W-1:0]  smp_idx_q, smp_idx_d;
    logic [DIST_W-1:0] smp_cm_q, smp_cm_d;
    logic              smp_to_q, smp_to_d;
    logic [DIST_W-1:0] min_cm_q, min_cm_d;
    logic [IDX_W-1:0]  min_idx_q, min_idx_d;
    logic [DIST_W-1:0] near_cm_q, near_cm_d;
    logic [IDX_W-1:0]  near_idx_q, near_idx_d;
    logic              wrap;
    logic              at_end;

    servo_pwm_gen #(
        .SERVO_PERIOD (SERVO_PERIOD),
        .PULSE_MIN    (PULSE_MIN),
        .PULSE_STEP   (PULSE_STEP)
    ) u_pwm (
        .clk       (clk),
        .rst       (rst),
        .angle_idx (idx_q),
        .servo_pwm (servo_pwm),
        .wrap      (wrap)
    );

    assign at_end = dir_up_q ? (idx_q == IDX_W'(N_POS - 1)) : (idx_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            dir_up_q   <= 1'b1;
            settle_q   <= '0;
            tmo_q      <= '0;
            smp_idx_q  <= '0;
            smp_cm_q   <= '0;
            smp_to_q   <= 1'b0;
            min_cm_q   <= DIST_NONE;
            min_idx_q  <= '0;
            near_cm_q  <= DIST_NONE;
            near_idx_q <= '0;
        end else begin
            idx_q      <= idx_d;
            dir_up_q   <= dir_up_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            smp_idx_q  <= smp_idx_d;
            smp_cm_q   <= smp_cm_d;
            smp_to_q   <= smp_to_d;
            min_cm_q   <= min_cm_d;
            min_idx_q  <= min_idx_d;
            near_cm_q  <= near_cm_d;
            near_idx_q <= near_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dir_up_d   = dir_up_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        smp_idx_d  = smp_idx_q;
        smp_cm_d   = smp_cm_q;
        smp_to_d   = smp_to_q;
        min_cm_d   = min_cm_q;
        min_idx_d  = min_idx_q;
        near_cm_d  = near_cm_q;
        near_idx_d = near_idx_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StSettle;
                    settle_d = '0;
                end
            end
            StSettle: begin
                if (wrap) begin
                    if (settle_q == SET_W'(SETTLE_FRAMES - 1)) begin
                        state_d = StMeasure;
                        tmo_d   = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            StMeasure: begin
                tmo_d = tmo_q + 1'b1;
                // A result on the final timeout cycle still counts as a real measurement.
                if (bus.meas_valid) begin
                    state_d   = StReport;
                    smp_idx_d = idx_q;
                    smp_cm_d  = bus.distance_cm;
                    smp_to_d  = 1'b0;
                end else if (tmo_q == TMO_W'(MEAS_TIMEOUT - 1)) begin
                    state_d   = StReport;
                    smp_idx_d = idx_q;
                    smp_cm_d  = DIST_NONE;
                    smp_to_d  = 1'b1;
                end
            end
            StReport: begin
                state_d = StAdvance;
                if (smp_cm_q < min_cm_q) begin
                    min_cm_d  = smp_cm_q;
                    min_idx_d = smp_idx_q;
                end
            end
            StAdvance: begin
                // Reversal steps straight off the endpoint so it is not sampled twice.
                if (at_end) begin
                    dir_up_d   = ~dir_up_q;
                    near_cm_d  = min_cm_q;
                    near_idx_d = min_idx_q;
                    min_cm_d   = DIST_NONE;
                    min_idx_d  = '0;
                end
                idx_d = (dir_up_q ^ at_end) ? idx_q + 1'b1 : idx_q - 1'b1;
                if (enable) begin
                    state_d  = StSettle;
                    settle_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        angle_idx          = idx_q;
        bus.meas_req       = (state_q == StMeasure) && (tmo_q == '0);
        bus.sample_valid   = (state_q == StReport);
        bus.sample_idx     = smp_idx_q;
        bus.sample_cm      = smp_cm_q;
        bus.sample_timeout = smp_to_q;
        bus.sweep_done     = (state_q == StAdvance) && at_end;
        bus.nearest_cm     = near_cm_q;
        bus.nearest_idx    = near_idx_q;
    end

endmodule
